// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/EXT arbiter for a single-ported memory; MEM_PORT_ARBITER_RR_EN selects round-robin arbitration
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LAT        = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuAddr,
    input  logic [DW-1:0] cpuWdata,
    output logic [DW-1:0] cpuRdata,
    output logic          cpuAck,
    input  logic          extReq,
    input  logic          extWe,
    input  logic [AW-1:0] extAddr,
    input  logic [DW-1:0] extWdata,
    output logic [DW-1:0] extRdata,
    output logic          extAck,
    output logic          memEn,
    output logic          memWe,
    output logic [AW-1:0] memAddr,
    output logic [DW-1:0] memWdata,
    input  logic [DW-1:0] memRdata,
    output logic          busy,
    output logic          ownerExt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [3:0]    wait_cnt, wait_cnt_nx;
    logic          grant_ext;
    logic          mem_en_nx, mem_we_nx, cpu_ack_nx, ext_ack_nx, busy_nx, owner_ext_nx;
    logic [AW-1:0] mem_addr_nx;
    logic [DW-1:0] mem_wdata_nx, cpu_rdata_nx, ext_rdata_nx;

`ifdef MEM_PORT_ARBITER_RR_EN
    logic last_ext, last_ext_nx;

    // On a tie the requester that did not win the previous grant goes first
    always_comb grant_ext = extReq && (!cpuReq || !last_ext);
`else
    logic [3:0] starve_cnt, starve_cnt_nx;

    // CPU has priority until EXT has been passed over STARVE_MAX times in a row
    always_comb grant_ext = extReq && (!cpuReq || (starve_cnt == 4'(STARVE_MAX)));
`endif

    // Next-state and next-output decode; every output is registered below
    always_comb begin
        state_nx     = state;
        wait_cnt_nx  = wait_cnt;
        mem_we_nx    = memWe;
        mem_addr_nx  = memAddr;
        mem_wdata_nx = memWdata;
        cpu_rdata_nx = cpuRdata;
        ext_rdata_nx = extRdata;
        cpu_ack_nx   = 1'b0;
        ext_ack_nx   = 1'b0;
        owner_ext_nx = ownerExt;
`ifdef MEM_PORT_ARBITER_RR_EN
        last_ext_nx  = last_ext;
`else
        starve_cnt_nx = starve_cnt;
`endif
        case (state)
            IDLE: begin
                if (cpuReq || extReq) begin
                    state_nx     = ISSUE;
                    owner_ext_nx = grant_ext;
                    mem_we_nx    = grant_ext ? extWe    : cpuWe;
                    mem_addr_nx  = grant_ext ? extAddr  : cpuAddr;
                    mem_wdata_nx = grant_ext ? extWdata : cpuWdata;
`ifdef MEM_PORT_ARBITER_RR_EN
                    last_ext_nx  = grant_ext;
`endif
                end
`ifndef MEM_PORT_ARBITER_RR_EN
                // CPU only wins against a waiting EXT while below the bound, so no overflow
                if (!extReq || grant_ext) begin
                    starve_cnt_nx = 4'd0;
                end else begin
                    starve_cnt_nx = starve_cnt + 4'd1;
                end
`endif
            end
            ISSUE: begin
                state_nx    = WAIT;
                wait_cnt_nx = 4'(LAT - 1);
            end
            WAIT: begin
                // Last WAIT cycle is issue+LAT, when memRdata is valid
                if (wait_cnt == 4'd0) begin
                    state_nx = RESP;
                    if (ownerExt) begin
                        ext_rdata_nx = memRdata;
                        ext_ack_nx   = 1'b1;
                    end else begin
                        cpu_rdata_nx = memRdata;
                        cpu_ack_nx   = 1'b1;
                    end
                end else begin
                    wait_cnt_nx = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx     = IDLE;
                owner_ext_nx = 1'b0;
            end
            default: state_nx = IDLE;
        endcase
        mem_en_nx = (state_nx == ISSUE);
        busy_nx   = (state_nx != IDLE);
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            memEn    <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= '0;
            memWdata <= '0;
            cpuRdata <= '0;
            extRdata <= '0;
            cpuAck   <= 1'b0;
            extAck   <= 1'b0;
            busy     <= 1'b0;
            ownerExt <= 1'b0;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_ext <= 1'b0;
`else
            starve_cnt <= 4'd0;
`endif
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            memEn    <= mem_en_nx;
            memWe    <= mem_we_nx;
            memAddr  <= mem_addr_nx;
            memWdata <= mem_wdata_nx;
            cpuRdata <= cpu_rdata_nx;
            extRdata <= ext_rdata_nx;
            cpuAck   <= cpu_ack_nx;
            extAck   <= ext_ack_nx;
            busy     <= busy_nx;
            ownerExt <= owner_ext_nx;
`ifdef MEM_PORT_ARBITER_RR_EN
            last_ext <= last_ext_nx;
`else
            starve_cnt <= starve_cnt_nx;
`endif
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - bench for mem_port_arbiter (honours MEM_PORT_ARBITER_RR_EN)
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int SMAX = 4;
    localparam logic [31:0] JUNK = 32'hBADBAD00;
    localparam int M_NONE = 0, M_HOLD = 1, M_RAND = 2;

    logic clk = 1'b0;
    logic rstN;
    always #5 clk = ~clk;

    logic        cpuReq, cpuWe, extReq, extWe;
    logic [31:0] cpuAddr, cpuWdata, extAddr, extWdata, memRdata;
    logic [31:0] cpuRdata, extRdata, memAddr, memWdata;
    logic        cpuAck, extAck, memEn, memWe, busy, ownerExt;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(LAT), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rstN(rstN),
        .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWdata(cpuWdata),
        .cpuRdata(cpuRdata), .cpuAck(cpuAck),
        .extReq(extReq), .extWe(extWe), .extAddr(extAddr), .extWdata(extWdata),
        .extRdata(extRdata), .extAck(extAck),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata), .busy(busy), .ownerExt(ownerExt)
    );

    logic        c1_req, c1_we, x1_req, x1_we;
    logic [31:0] c1_addr, c1_wdata, x1_addr, x1_wdata, m1_rdata;
    logic [31:0] c1_rdata, x1_rdata, m1_addr, m1_wdata;
    logic        c1_ack, x1_ack, m1_en, m1_we, busy1, owner1;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1), .STARVE_MAX(SMAX)) dut1 (
        .clk(clk), .rstN(rstN),
        .cpuReq(c1_req), .cpuWe(c1_we), .cpuAddr(c1_addr), .cpuWdata(c1_wdata),
        .cpuRdata(c1_rdata), .cpuAck(c1_ack),
        .extReq(x1_req), .extWe(x1_we), .extAddr(x1_addr), .extWdata(x1_wdata),
        .extRdata(x1_rdata), .extAck(x1_ack),
        .memEn(m1_en), .memWe(m1_we), .memAddr(m1_addr), .memWdata(m1_wdata),
        .memRdata(m1_rdata), .busy(busy1), .ownerExt(owner1)
    );

    // memory macro models: data valid exactly LAT cycles after the memEn cycle
    logic [31:0] bmem [256];
    logic [31:0] ref_mem [256];
    int          pend = 0, pend1 = 0;
    logic [31:0] pend_data = 32'h0, pend1_data = 32'h0;

    initial forever begin
        @(negedge clk);
        if (memEn === 1'b1) begin
            if (memWe) begin
                bmem[memAddr[9:2]] = memWdata;
                pend_data = ~memWdata;
            end else begin
                pend_data = bmem[memAddr[9:2]];
            end
            pend = LAT;
        end
        if (m1_en === 1'b1) begin
            pend1_data = m1_addr ^ 32'hA5A50000;
            pend1 = 1;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        memRdata = JUNK;
        if (pend > 0) begin
            pend = pend - 1;
            if (pend == 0) memRdata = pend_data;
        end
        m1_rdata = JUNK;
        if (pend1 > 0) begin
            pend1 = pend1 - 1;
            if (pend1 == 0) m1_rdata = pend1_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int checks = 0, errors = 0;

    // transaction-level reference: arbiter idle at idle_c, each grant takes LAT+3 cycles
    int          c, idle_c, issue_c, ack_c, starve;
    bit          own_ext, last_ext, glog_en;
    bit          glog[$];
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_resp, e_cpu_rd, e_ext_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        idle_c = c; issue_c = -1; ack_c = -1; starve = 0; last_ext = 1'b0;
        own_ext = 1'b0; e_cpu_rd = 32'h0; e_ext_rd = 32'h0;
    endtask

    task automatic step(input int mode);
        bit busy_e, cpu_drop, ext_drop, win;
        busy_e = (issue_c >= 0) && (c >= issue_c) && (c <= ack_c);
        if (c == ack_c) begin
            if (own_ext) e_ext_rd = e_resp;
            else e_cpu_rd = e_resp;
        end
        chk("memEn", 32'(memEn), 32'(c == issue_c));
        chk("busy", 32'(busy), 32'(busy_e));
        chk("cpuAck", 32'(cpuAck), 32'(c == ack_c && !own_ext));
        chk("extAck", 32'(extAck), 32'(c == ack_c && own_ext));
        chk("cpuRdata", cpuRdata, e_cpu_rd);
        chk("extRdata", extRdata, e_ext_rd);
        if (c == issue_c) begin
            chk("memAddr", memAddr, e_addr);
            chk("memWe", 32'(memWe), 32'(e_we));
            chk("memWdata", memWdata, e_wdata);
            if (glog_en) glog.push_back(ownerExt);
        end
        if (busy_e) chk("ownerExt", 32'(ownerExt), 32'(own_ext));

        cpu_drop = 1'b0; ext_drop = 1'b0;
        if (c == ack_c) begin
            if (own_ext) begin extReq = 1'b0; ext_drop = 1'b1; end
            else begin cpuReq = 1'b0; cpu_drop = 1'b1; end
        end
        if (!cpuReq && !cpu_drop && (mode == M_HOLD || (mode == M_RAND && $urandom_range(0, 2) == 0))) begin
            cpuReq = 1'b1; cpuWe = 1'($urandom_range(0, 1));
            cpuAddr = 32'($urandom_range(0, 255)) << 2; cpuWdata = $urandom;
        end
        if (!extReq && !ext_drop && (mode == M_HOLD || (mode == M_RAND && $urandom_range(0, 3) == 0))) begin
            extReq = 1'b1; extWe = 1'($urandom_range(0, 1));
            extAddr = 32'($urandom_range(0, 255)) << 2; extWdata = $urandom;
        end

        if (c == idle_c) begin
            win = 1'b0;
            if (cpuReq || extReq) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                win = (cpuReq && extReq) ? !last_ext : extReq;
                last_ext = win;
`else
                win = extReq && (!cpuReq || starve == SMAX);
`endif
                e_we    = win ? extWe : cpuWe;
                e_addr  = win ? extAddr : cpuAddr;
                e_wdata = win ? extWdata : cpuWdata;
                if (e_we) begin
                    ref_mem[e_addr[9:2]] = e_wdata;
                    e_resp = ~e_wdata;
                end else begin
                    e_resp = ref_mem[e_addr[9:2]];
                end
                own_ext = win;
                issue_c = c + 1; ack_c = c + LAT + 2; idle_c = c + LAT + 3;
            end else begin
                idle_c = c + 1;
            end
            if (!extReq || win) starve = 0;
            else if (starve < SMAX) starve = starve + 1;
        end
        c++;
        @(negedge clk);
    endtask

    initial begin
        int guard, saved;
        bit pat;
        for (int i = 0; i < 256; i++) begin
            bmem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
            ref_mem[i] = bmem[i];
        end
        bmem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
        cpuReq = 0; cpuWe = 0; cpuAddr = 0; cpuWdata = 0;
        extReq = 0; extWe = 0; extAddr = 0; extWdata = 0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        x1_req = 0; x1_we = 0; x1_addr = 0; x1_wdata = 0;
        glog_en = 1'b0; e_we = 0; e_addr = 0; e_wdata = 0; e_resp = 0;
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_memEn", 32'(memEn), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_cpuRdata", cpuRdata, 32'h0);
        rstN = 1'b1;
        c = 0;
        model_reset();

        // CPU read of 0x40, then EXT write of 0x12345678 to 0x10
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h40; cpuWdata = 32'h0;
        repeat (7) step(M_NONE);
        chk("t1_cpuRdata", cpuRdata, 32'hDEADBEEF);
        extReq = 1'b1; extWe = 1'b1; extAddr = 32'h10; extWdata = 32'h12345678;
        repeat (7) step(M_NONE);
        chk("t2_mem", bmem[4], 32'h12345678);

        // both requesters held high
        glog_en = 1'b1;
        repeat (60) step(M_HOLD);
        glog_en = 1'b0;
        chk("grant_count", 32'(glog.size() >= 10), 32'h1);
        for (int i = 0; i < 10 && i < glog.size(); i++) begin
`ifdef MEM_PORT_ARBITER_RR_EN
            pat = (i % 2) == 1;
`else
            pat = (i % 5) == 4;
`endif
            chk($sformatf("grant_order[%0d]", i), 32'(glog[i]), 32'(pat));
        end
        guard = 0;
        while ((cpuReq || extReq || c != idle_c) && guard < 100) begin step(M_NONE); guard++; end
        chk("drain1", 32'(guard < 100), 32'h1);

        // randomised traffic
        repeat (400) step(M_RAND);
        guard = 0;
        while ((cpuReq || extReq || c != idle_c) && guard < 100) begin step(M_NONE); guard++; end
        chk("drain2", 32'(guard < 100), 32'h1);

        // reset during WAIT of a CPU read
        cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 32'h80; cpuWdata = 32'h0;
        saved = c; guard = 0;
        while (!(issue_c > saved && c == issue_c + 1) && guard < 20) begin step(M_NONE); guard++; end
        chk("reach_wait", 32'(guard < 20), 32'h1);
        rstN = 1'b0;
        #1;
        chk("arst_memEn", 32'(memEn), 32'h0);
        chk("arst_memWe", 32'(memWe), 32'h0);
        chk("arst_memAddr", memAddr, 32'h0);
        chk("arst_memWdata", memWdata, 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_ownerExt", 32'(ownerExt), 32'h0);
        chk("arst_cpuAck", 32'(cpuAck), 32'h0);
        chk("arst_extAck", 32'(extAck), 32'h0);
        chk("arst_cpuRdata", cpuRdata, 32'h0);
        chk("arst_extRdata", extRdata, 32'h0);
        @(negedge clk);
        c++;
        rstN = 1'b1;
        model_reset();
        repeat (8) step(M_NONE);

        // LAT=1 instance: back-to-back CPU reads of 0x0 and 0x4
        c1_req = 1'b1; c1_addr = 32'h0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("l1_memEn@%0d", k), 32'(m1_en), 32'(k == 1 || k == 5));
            chk($sformatf("l1_ack@%0d", k), 32'(c1_ack), 32'(k == 3 || k == 7));
            chk($sformatf("l1_busy@%0d", k), 32'(busy1), 32'((k >= 1 && k <= 3) || (k >= 5 && k <= 7)));
            if (k == 1) chk("l1_addr0", m1_addr, 32'h0);
            if (k == 5) chk("l1_addr4", m1_addr, 32'h4);
            if (k == 3) chk("l1_rdata0", c1_rdata, 32'hA5A50000);
            if (k == 7) chk("l1_rdata4", c1_rdata, 32'hA5A50004);
            if (k == 3) c1_addr = 32'h4;
            if (k == 7) c1_req = 1'b0;
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
